// File: rtl/cmos_pixel_packer.sv
// cmos_pixel_packer: packs the gated RGB565 camera stream into OUT_W-bit
// words for the write side of the camera-to-DMA async FIFO (cam_pclk domain).
// Tags words with start-of-frame / end-of-line, abandons a frame cleanly on
// FIFO overflow and flags malformed line/frame geometry.
// Optional build macro PACKER_TEST_PATTERN_EN: captured pixels are replaced by
// {line_cnt[7:0], pixel index in line[7:0]}; timing and handshake unchanged.
//
// Handshake: pack_wr_en is a one-cycle write strobe into a FIFO that offers no
// back-pressure other than pack_full. pack_full is sampled only in the cycle a
// word completes; if it is high that word is not written and the frame is
// dropped. pack_data/pack_sof/pack_eol are meaningful only while pack_wr_en=1.
module cmos_pixel_packer #(
  parameter int PIX_W    = 16,
  parameter int OUT_W    = 128,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic             cam_pclk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             cmos_frame_vsync,
  input  logic             cmos_frame_href,
  input  logic             cmos_frame_valid,
  input  logic [PIX_W-1:0] cmos_frame_data,
  input  logic             pack_full,
  output logic [OUT_W-1:0] pack_data,
  output logic             pack_wr_en,
  output logic             pack_sof,
  output logic             pack_eol,
  output logic             frame_done,
  output logic             frame_dropped,
  output logic             err_len,
  output logic [11:0]      line_cnt,
  output logic [15:0]      frame_cnt,
  output logic [1:0]       fsm_state
);

  localparam int N      = OUT_W / PIX_W;
  localparam int LANE_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(H_ACTIVE + 1);

  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(N - 1);
  localparam logic [CNT_W-1:0]  PIX_LAST  = CNT_W'(H_ACTIVE);
  localparam logic [11:0]       LINE_LAST = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    ACTIVE   = 2'd2,
    DROP     = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic              vs_q;
  logic              frame_start;
  logic [CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [OUT_W-1:0]  word_q, word_d;
  logic              sof_arm_q, sof_arm_d;

  logic [OUT_W-1:0]  pack_data_d;
  logic              pack_wr_en_d, pack_sof_d, pack_eol_d;
  logic              frame_done_d, frame_dropped_d, err_len_d;
  logic [11:0]       line_cnt_d;
  logic [15:0]       frame_cnt_d;

  // Position and lane the current pixel lands in: an href in the same cycle
  // makes it the first pixel of the new line.
  logic [CNT_W-1:0]  pix_pos;
  logic [LANE_W-1:0] cur_lane;
  logic [PIX_W-1:0]  pix_val;

  assign frame_start = cmos_frame_vsync & ~vs_q;
  assign pix_pos     = cmos_frame_href ? '0 : pix_cnt_q;
  assign cur_lane    = cmos_frame_href ? '0 : lane_q;
  assign fsm_state   = state_q;

`ifdef PACKER_TEST_PATTERN_EN
  logic [31:0] pos_ext;
  assign pos_ext = 32'(pix_pos);
  assign pix_val = {line_cnt[7:0], pos_ext[7:0]};
`else
  assign pix_val = cmos_frame_data;
`endif

  // State register.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, packing datapath and output strobes.
  always_comb begin
    state_d         = state_q;
    pix_cnt_d       = pix_cnt_q;
    lane_d          = lane_q;
    word_d          = word_q;
    sof_arm_d       = sof_arm_q;
    line_cnt_d      = line_cnt;
    frame_cnt_d     = frame_cnt;
    pack_data_d     = pack_data;
    pack_wr_en_d    = 1'b0;
    pack_sof_d      = 1'b0;
    pack_eol_d      = 1'b0;
    frame_done_d    = 1'b0;
    frame_dropped_d = 1'b0;
    err_len_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = WAIT_SOF;
      end

      WAIT_SOF, DROP: begin
        if (frame_start) begin
          state_d    = enable ? ACTIVE : IDLE;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          lane_d     = '0;
          sof_arm_d  = 1'b1;
        end
      end

      ACTIVE: begin
        if (frame_start) begin
          // Frame ended early: discard the partial word and start over.
          err_len_d  = 1'b1;
          line_cnt_d = '0;
          pix_cnt_d  = '0;
          lane_d     = '0;
          sof_arm_d  = 1'b1;
        end else begin
          if (cmos_frame_href) begin
            if (pix_cnt_q != '0 && pix_cnt_q != PIX_LAST) err_len_d = 1'b1;
            pix_cnt_d = '0;
            lane_d    = '0;
          end
          if (cmos_frame_valid) begin
            if (pix_pos == PIX_LAST) begin
              err_len_d = 1'b1;
            end else begin
              word_d[cur_lane*PIX_W +: PIX_W] = pix_val;
              pix_cnt_d = pix_pos + CNT_W'(1);
              if (cur_lane == LANE_LAST) begin
                lane_d = '0;
                if (pack_full) begin
                  frame_dropped_d = 1'b1;
                  state_d         = DROP;
                end else begin
                  pack_wr_en_d = 1'b1;
                  pack_data_d  = word_d;
                  pack_sof_d   = sof_arm_q;
                  sof_arm_d    = 1'b0;
                  pack_eol_d   = (pix_cnt_d == PIX_LAST);
                  if (pix_cnt_d == PIX_LAST) begin
                    line_cnt_d = line_cnt + 12'd1;
                    if (line_cnt_d == LINE_LAST) begin
                      frame_done_d = 1'b1;
                      frame_cnt_d  = frame_cnt + 16'd1;
                      state_d      = enable ? WAIT_SOF : IDLE;
                    end
                  end
                end
              end else begin
                lane_d = cur_lane + LANE_W'(1);
              end
            end
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge cam_pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q          <= 1'b0;
      pix_cnt_q     <= '0;
      lane_q        <= '0;
      word_q        <= '0;
      sof_arm_q     <= 1'b0;
      line_cnt      <= '0;
      frame_cnt     <= '0;
      pack_data     <= '0;
      pack_wr_en    <= 1'b0;
      pack_sof      <= 1'b0;
      pack_eol      <= 1'b0;
      frame_done    <= 1'b0;
      frame_dropped <= 1'b0;
      err_len       <= 1'b0;
    end else begin
      vs_q          <= cmos_frame_vsync;
      pix_cnt_q     <= pix_cnt_d;
      lane_q        <= lane_d;
      word_q        <= word_d;
      sof_arm_q     <= sof_arm_d;
      line_cnt      <= line_cnt_d;
      frame_cnt     <= frame_cnt_d;
      pack_data     <= pack_data_d;
      pack_wr_en    <= pack_wr_en_d;
      pack_sof      <= pack_sof_d;
      pack_eol      <= pack_eol_d;
      frame_done    <= frame_done_d;
      frame_dropped <= frame_dropped_d;
      err_len       <= err_len_d;
    end
  end

endmodule
